// File: rtl/vmem_write_scheduler.sv
// Video RAM write-port owner: CPU pixel writes pass through with one cycle of latency,
// and a rectangle-fill engine uses the port on every cycle the CPU leaves free.
module vmem_write_scheduler #(
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int X_SIZE     = 400,
  parameter int Y_SIZE     = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCpuWrite,
  input  logic [X_WIDTH-1:0]    iCpuX,
  input  logic [Y_WIDTH-1:0]    iCpuY,
  input  logic [DATA_WIDTH-1:0] iCpuColor,
  input  logic                  iFillStart,
  input  logic [X_WIDTH-1:0]    iFillX0,
  input  logic [X_WIDTH-1:0]    iFillX1,
  input  logic [Y_WIDTH-1:0]    iFillY0,
  input  logic [Y_WIDTH-1:0]    iFillY1,
  input  logic [DATA_WIDTH-1:0] iFillColor,
  output logic                  oFillBusy,
  output logic                  oFillDone,
  output logic                  oFillError,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [X_WIDTH-1:0]    X_MAX     = X_WIDTH'(X_SIZE - 1);
  localparam logic [Y_WIDTH-1:0]    Y_MAX     = Y_WIDTH'(Y_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_PITCH = ADDR_WIDTH'(X_SIZE);

  function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic [X_WIDTH-1:0] x,
                                                       input logic [Y_WIDTH-1:0] y);
    return ROW_PITCH * ADDR_WIDTH'(y) + ADDR_WIDTH'(x);
  endfunction

  state_e state_q, state_d;

  logic [X_WIDTH-1:0]    x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_WIDTH-1:0]    y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [X_WIDTH-1:0] x1_clamped;
  logic [Y_WIDTH-1:0] y1_clamped;
  logic               rect_reject;
  logic               fill_issue;
  logic               fill_last;
  logic               start_accept;

  // Clamping X1/Y1 also covers X0/Y0 beyond the screen: they then exceed the clamped bound.
  assign x1_clamped   = (iFillX1 > X_MAX) ? X_MAX : iFillX1;
  assign y1_clamped   = (iFillY1 > Y_MAX) ? Y_MAX : iFillY1;
  assign rect_reject  = (iFillX0 > x1_clamped) || (iFillY0 > y1_clamped);
  assign start_accept = (state_q == S_IDLE) && iFillStart;
  assign fill_issue   = (state_q == S_RUN) && !iCpuWrite;
  assign fill_last    = (x_q == x1_q) && (y_q == y1_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (iFillStart) state_d = rect_reject ? S_DONE : S_RUN;
      S_RUN:   if (fill_issue && fill_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oFillBusy  = (state_q != S_IDLE);
    oFillDone  = (state_q == S_DONE);
    oFillError = (state_q == S_DONE) && err_q;
  end

  always_comb begin
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (start_accept) begin
      x0_d    = iFillX0;
      x1_d    = x1_clamped;
      y0_d    = iFillY0;
      y1_d    = y1_clamped;
      x_d     = iFillX0;
      y_d     = iFillY0;
      color_d = iFillColor;
      err_d   = rect_reject;
    end else if (state_q == S_DONE) begin
      err_d = 1'b0;
    end

    if (fill_issue) begin
      we_d   = 1'b1;
      addr_d = pixel_addr(x_q, y_q);
      data_d = color_q;
      if (x_q == x1_q) begin
        x_d = x0_q;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // The CPU cannot stall, so its pixel always owns the port; the fill cursor holds meanwhile.
    if (iCpuWrite) begin
      we_d   = 1'b1;
      addr_d = pixel_addr(iCpuX, iCpuY);
      data_d = iCpuColor;
    end
  end

  // NOTE: every register here is reset, because the write outputs and fill bounds must read 0 out of reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oWriteData    = data_q;

endmodule

// File: tb/tb_vmem_write_scheduler.sv
// Bench for vmem_write_scheduler: directed scenarios plus a random phase, checked every
// cycle against a queue-based model of the fill/CPU write stream.
module tb_vmem_write_scheduler;
  localparam int XS = 400;
  localparam int YS = 240;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iCpuWrite = 1'b0;
  logic [8:0] iCpuX = '0;
  logic [7:0] iCpuY = '0;
  logic [2:0] iCpuColor = '0;
  logic       iFillStart = 1'b0;
  logic [8:0] iFillX0 = '0, iFillX1 = '0;
  logic [7:0] iFillY0 = '0, iFillY1 = '0;
  logic [2:0] iFillColor = '0;
  logic        oFillBusy, oFillDone, oFillError, oWriteEnable;
  logic [16:0] oWriteAddress;
  logic [2:0]  oWriteData;

  always #5 Clock = ~Clock;

  vmem_write_scheduler dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWrite(iCpuWrite), .iCpuX(iCpuX), .iCpuY(iCpuY), .iCpuColor(iCpuColor),
    .iFillStart(iFillStart), .iFillX0(iFillX0), .iFillX1(iFillX1),
    .iFillY0(iFillY0), .iFillY1(iFillY1), .iFillColor(iFillColor),
    .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oFillError(oFillError),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oWriteData(oWriteData)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: a pending fill is the list of its remaining pixel addresses.
  int          m_phase;   // 0 idle, 1 filling, 2 done cycle
  int          mq[$];
  bit          m_err;
  logic        m_we;
  logic [31:0] m_addr, m_data;
  logic [2:0]  m_color;

  task automatic model_reset();
    m_phase = 0; mq.delete(); m_err = 0; m_we = 0; m_addr = 0; m_data = 0; m_color = 0;
  endtask

  task automatic model_edge();
    int x1c, y1c;
    m_we = 0;
    case (m_phase)
      0: if (iFillStart) begin
        x1c = (int'(iFillX1) > XS - 1) ? XS - 1 : int'(iFillX1);
        y1c = (int'(iFillY1) > YS - 1) ? YS - 1 : int'(iFillY1);
        if (int'(iFillX0) > x1c || int'(iFillY0) > y1c) begin
          m_phase = 2; m_err = 1;
        end else begin
          for (int y = int'(iFillY0); y <= y1c; y++)
            for (int x = int'(iFillX0); x <= x1c; x++) mq.push_back(XS * y + x);
          m_color = iFillColor;
          m_phase = 1;
        end
      end
      1: if (!iCpuWrite) begin
        m_we = 1; m_addr = mq.pop_front(); m_data = 32'(m_color);
        if (mq.size() == 0) m_phase = 2;
      end
      default: begin m_phase = 0; m_err = 0; end
    endcase
    if (iCpuWrite) begin
      m_we = 1;
      m_addr = (XS * int'(iCpuY) + int'(iCpuX)) % (1 << 17);
      m_data = 32'(iCpuColor);
    end
  endtask

  // Per-scenario observations
  int         fill_w[$];
  logic [2:0] fill_d[$];
  int cpu_hits, done_cnt, err_cnt, busy_cnt, done_idx, cyc, we_cnt;
  bit last_cpu;

  task automatic clear_stats();
    fill_w.delete(); fill_d.delete();
    cpu_hits = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; done_idx = -1; cyc = -1; we_cnt = 0;
  endtask

  task automatic step();
    @(posedge Clock);
    last_cpu = iCpuWrite;
    if (!Reset) model_reset();
    else        model_edge();
    @(negedge Clock);
    cyc++;
    check("we", 32'(oWriteEnable), 32'(m_we));
    check("addr", 32'(oWriteAddress), m_addr);
    check("data", 32'(oWriteData), m_data);
    check("busy", 32'(oFillBusy), 32'(m_phase != 0));
    check("done", 32'(oFillDone), 32'(m_phase == 2));
    check("error", 32'(oFillError), 32'(m_err && m_phase == 2));
    if (oWriteEnable) begin
      we_cnt++;
      if (last_cpu) begin
        if (oWriteAddress == 17'd0 && oWriteData == 3'b010) cpu_hits++;
      end else begin
        fill_w.push_back(int'(oWriteAddress));
        fill_d.push_back(oWriteData);
      end
    end
    if (oFillDone) begin done_cnt++; done_idx = cyc; end
    if (oFillError) err_cnt++;
    if (oFillBusy) busy_cnt++;
  endtask

  task automatic start_fill(input int x0, input int x1, input int y0, input int y1, input int col);
    iFillX0 = 9'(x0); iFillX1 = 9'(x1); iFillY0 = 8'(y0); iFillY1 = 8'(y1); iFillColor = 3'(col);
    iFillStart = 1'b1;
    clear_stats();
    step();
    iFillStart = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (oFillBusy === 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(oFillBusy), 32'd0);
  endtask

  task automatic check_basic_list(input string tag);
    int exp_b[6] = '{402, 403, 404, 802, 803, 804};
    check({tag, "_count"}, 32'(fill_w.size()), 32'd6);
    for (int i = 0; i < 6 && i < fill_w.size(); i++) begin
      check({tag, "_addr"}, 32'(fill_w[i]), 32'(exp_b[i]));
      check({tag, "_color"}, 32'(fill_d[i]), 32'd5);
    end
  endtask

  initial begin
    model_reset();
    clear_stats();
    repeat (2) step();
    check("rst_we", 32'(oWriteEnable), 32'd0);
    check("rst_addr", 32'(oWriteAddress), 32'd0);
    check("rst_busy", 32'(oFillBusy), 32'd0);
    Reset = 1'b1;
    step();

    // Basic fill
    start_fill(2, 4, 1, 2, 5);
    check("basic_busy_rise", 32'(oFillBusy), 32'd1);
    wait_idle(50);
    check_basic_list("basic");
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_done_idx", 32'(done_idx), 32'd6);
    check("basic_busy_cycles", 32'(busy_cnt), 32'd7);
    check("basic_err_cnt", 32'(err_cnt), 32'd0);

    // Contention: two CPU writes to (0,0) mid-fill
    start_fill(2, 4, 1, 2, 5);
    step(); step();
    iCpuWrite = 1'b1; iCpuX = 9'd0; iCpuY = 8'd0; iCpuColor = 3'b010;
    step(); step();
    iCpuWrite = 1'b0;
    wait_idle(50);
    check_basic_list("contend");
    check("contend_cpu_hits", 32'(cpu_hits), 32'd2);
    check("contend_done_idx", 32'(done_idx), 32'd8);
    check("contend_busy_cycles", 32'(busy_cnt), 32'd9);

    // Clamp at the bottom-right corner
    start_fill(398, 500, 239, 255, 3);
    wait_idle(50);
    check("clamp_count", 32'(fill_w.size()), 32'd2);
    if (fill_w.size() == 2) begin
      check("clamp_addr0", 32'(fill_w[0]), 32'd95998);
      check("clamp_addr1", 32'(fill_w[1]), 32'd95999);
    end
    check("clamp_done_cnt", 32'(done_cnt), 32'd1);
    check("clamp_err_cnt", 32'(err_cnt), 32'd0);

    // Rejected rectangle
    start_fill(5, 3, 0, 0, 1);
    check("reject_done", 32'(oFillDone), 32'd1);
    check("reject_error", 32'(oFillError), 32'd1);
    wait_idle(10);
    check("reject_writes", 32'(we_cnt), 32'd0);
    check("reject_err_cnt", 32'(err_cnt), 32'd1);
    check("reject_done_idx", 32'(done_idx), 32'd0);

    // Start ignored while busy
    start_fill(2, 4, 1, 2, 5);
    step();
    iFillX0 = 9'd0; iFillX1 = 9'd9; iFillY0 = 8'd0; iFillY1 = 8'd9; iFillColor = 3'd1;
    iFillStart = 1'b1;
    step();
    iFillStart = 1'b0;
    wait_idle(50);
    check_basic_list("ignore");
    check("ignore_done_cnt", 32'(done_cnt), 32'd1);

    // CPU write coincident with a start in IDLE
    iCpuWrite = 1'b1; iCpuX = 9'd7; iCpuY = 8'd3; iCpuColor = 3'd6;
    start_fill(2, 4, 1, 2, 5);
    iCpuWrite = 1'b0;
    check("coinc_cpu_addr", 32'(oWriteAddress), 32'd1207);
    check("coinc_cpu_data", 32'(oWriteData), 32'd6);
    wait_idle(50);
    check_basic_list("coinc");

    // Asynchronous reset in the middle of a 10x10 fill
    start_fill(0, 9, 0, 9, 4);
    repeat (20) step();
    #2 Reset = 1'b0;
    #1;
    check("arst_we", 32'(oWriteEnable), 32'd0);
    check("arst_addr", 32'(oWriteAddress), 32'd0);
    check("arst_data", 32'(oWriteData), 32'd0);
    check("arst_busy", 32'(oFillBusy), 32'd0);
    check("arst_done", 32'(oFillDone), 32'd0);
    check("arst_error", 32'(oFillError), 32'd0);
    model_reset();
    repeat (2) step();
    Reset = 1'b1;
    clear_stats();
    repeat (20) step();
    check("arst_no_writes", 32'(we_cnt), 32'd0);
    check("arst_no_done", 32'(done_cnt), 32'd0);
    check("arst_no_busy", 32'(busy_cnt), 32'd0);

    // Random traffic; the per-cycle model comparison does the checking
    for (int c = 0; c < 2000; c++) begin
      int x0, y0;
      iCpuWrite = ($urandom_range(0, 99) < 30);
      iCpuX = 9'($urandom_range(0, 511));
      iCpuY = 8'($urandom_range(0, 255));
      iCpuColor = 3'($urandom_range(0, 7));
      iFillStart = ($urandom_range(0, 99) < 8);
      x0 = int'($urandom_range(0, 405));
      y0 = int'($urandom_range(0, 245));
      iFillX0 = 9'(x0);
      iFillX1 = 9'(x0 + int'($urandom_range(0, 6)) - 1);
      iFillY0 = 8'(y0);
      iFillY1 = 8'(y0 + int'($urandom_range(0, 3)) - 1);
      iFillColor = 3'($urandom_range(0, 7));
      step();
    end
    iCpuWrite = 1'b0;
    iFillStart = 1'b0;
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
